// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - push/pop sequencer and stack pointer for the single-port stack memory
module stack_ctrl #(
  parameter int IA_WIDTH = 13,
  parameter int D_WIDTH  = 34
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic [D_WIDTH-1:0]  push_data_i,
  output logic                push_ready_o,
  input  logic                pop_i,
  output logic                pop_ready_o,
  output logic                pop_valid_o,
  output logic [D_WIDTH-1:0]  pop_data_o,
  input  logic                clear_i,
  input  logic                err_clr_i,
  output logic [IA_WIDTH:0]   count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic                mem_we_o,
  output logic [IA_WIDTH-1:0] mem_addr_o,
  output logic [D_WIDTH-1:0]  mem_din_o,
  input  logic [D_WIDTH-1:0]  mem_dout_i
);

  localparam int DEPTH = 2 ** IA_WIDTH;
  localparam logic [IA_WIDTH:0] SP_ONE  = (IA_WIDTH + 1)'(1);
  localparam logic [IA_WIDTH:0] SP_FULL = (IA_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IA_WIDTH:0]   sp, sp_nxt, sp_dec;
  logic                is_idle;
  logic                ovf_set, unf_set;

  assign sp_dec      = sp - SP_ONE;
  assign is_idle     = (state == IDLE);
  assign count_o     = sp;
  assign empty_o     = (sp == '0);
  assign full_o      = (sp == SP_FULL);
  assign pop_valid_o = (state == CAP);

  assign pop_ready_o  = is_idle & ~empty_o;
  assign push_ready_o = is_idle & ~full_o & ~pop_i;

  // Error flags are flagged on the attempt itself, independent of clear_i.
  assign ovf_set = is_idle & push_i & ~pop_i & full_o;
  assign unf_set = is_idle & pop_i & empty_o;

  always_comb begin
    state_nxt  = state;
    sp_nxt     = sp;
    mem_we_o   = 1'b0;
    mem_addr_o = sp_dec[IA_WIDTH-1:0];
    mem_din_o  = push_data_i;

    case (state)
      IDLE: begin
        if (!clear_i) begin
          if (pop_i && pop_ready_o) begin
            state_nxt = RD;
            sp_nxt    = sp_dec;
          end else if (push_i && push_ready_o) begin
            mem_we_o   = 1'b1;
            mem_addr_o = sp[IA_WIDTH-1:0];
            sp_nxt     = sp + SP_ONE;
          end
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A flush wins over any request but lets an in-flight pop finish.
    if (clear_i) begin
      sp_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sp          <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      pop_data_o  <= '0;
    end else begin
      state       <= state_nxt;
      sp          <= sp_nxt;
      overflow_o  <= ovf_set | (overflow_o & ~err_clr_i);
      underflow_o <= unf_set | (underflow_o & ~err_clr_i);
      if (state == RD) begin
        pop_data_o <= mem_dout_i;
      end
    end
  end

endmodule
